ps2_key_tracker: RTL
====================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 18, SHALL set the number of tracked note keys (1..32).
REQ-002 Parameter MONO, default 0, SHALL select the mode: 0 = polyphonic bitmap, 1 = monophonic last-note priority.
REQ-003 Port clk  input  1  SHALL be the single system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-004 Port resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port scan_data  input  8  SHALL be the received PS/2 byte from the PS/2 controller.
REQ-006 Port scan_valid  input  1  SHALL be the one-cycle strobe qualifying scan_data.
REQ-007 Port key_held  output  NUM_KEYS  SHALL have bit i high while note key i is held; in MONO=1, at most one bit is high.
REQ-008 Port note_valid  output  1  SHALL be high while at least one mapped key is held.
REQ-009 Port note_index  output  5  SHALL be the index of the sounding note: the most recent press in MONO=1, the lowest held index in MONO=0; 0 when note_valid is low.
REQ-010 Port key_count  output  6  SHALL be the number of held mapped keys.
REQ-011 Port key_event  output  1  SHALL be a one-cycle strobe on every change of key_held.
REQ-012 Port last_code  output  8  SHALL hold the last scan_data byte accepted, for the HEX display.

Function
REQ-013 The decoder SHALL process bytes only on clk cycles with scan_valid high; key_held SHALL NOT be clocked directly from scan_valid.
REQ-014 The decoder SHALL be an FSM with states IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0).
REQ-015 IDLE: F0 -> BRK, E0 -> EXT, any other byte is a make code -> IDLE.
REQ-016 BRK: any byte is a break code -> IDLE; EXT: F0 -> EXT_BRK, other -> IDLE; EXT_BRK: any byte -> IDLE.
REQ-017 Bytes consumed in EXT and EXT_BRK SHALL never change key_held, so extended keys are ignored.
REQ-018 A make code SHALL be translated by the keymap: A W S E D F T G Y H U J K O L P ; ' = 1C 1D 1B 24 23 2B 2C 34 35 33 3C 3B 42 44 4B 4D 4C 52 -> indices 0..17; indices >= NUM_KEYS and unmapped codes SHALL be ignored.
REQ-019 A make code for an already-held key (typematic repeat) SHALL NOT change state or pulse key_event.
REQ-020 A break code SHALL clear only its own key bit; a break for a key not held SHALL be ignored.
REQ-021 MONO=0: a make SHALL set its own bit without clearing the others.
REQ-022 MONO=1: a make SHALL set its own bit and clear all others, and note_index SHALL become that key.
REQ-023 MONO=1: releasing the sounding key SHALL set note_valid low; releasing a non-sounding key SHALL be ignored.
REQ-024 Bytes AA, FA, EE, FE and 00 SHALL be ignored in every state without a state change.
REQ-025 Outputs SHALL update on the clock edge after the qualifying scan_valid cycle (latency 1).
REQ-026 key_count SHALL equal the popcount of key_held in the same cycle.
REQ-027 last_code SHALL update on every scan_valid, including ignored bytes.

Reset
REQ-028 On resetn low, the FSM SHALL return to IDLE and key_held, key_count, note_index, note_valid, key_event and last_code SHALL be 0, asynchronously.
REQ-029 A break sequence interrupted by reset SHALL be discarded; the next byte SHALL be decoded from IDLE.

Structure
REQ-030 Package ps2_key_pkg SHALL hold the scancode constants (F0, E0, AA, FA, EE, FE), the FSM state enum and the default keymap table.
REQ-031 The scancode-to-index translation SHALL be a combinational sub-module ps2_keymap (outputs hit and index[4:0]).

Verification
REQ-032 Poly: 1C, then 1B -> key_held=0x00005, key_count=2, note_index=0; then F0 1C -> key_held=0x00004, note_index=2.
REQ-033 Typematic: 1C x5 -> key_held=0x00001, exactly one key_event pulse.
REQ-034 Extended: E0 F0 1C while A is held -> key_held unchanged at 0x00001; then F0 1C -> 0x00000, note_valid=0.
REQ-035 MONO=1: 1C, 23, F0 1C -> key_held=0x00010, note_index=4; F0 23 -> note_valid=0.
REQ-036 NUM_KEYS=8: make 3C (index 10) -> key_held=0, no key_event, last_code=3C.
REQ-037 Reset after F0 with A held -> all outputs 0; a following 1C -> key_held=0x00001.

Source files
------------

// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// ps2_key_pkg : scancode constants, decoder states and note keymap
// Rev 1.0
// ============================================================================
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERROR  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Piano-style layout: A W S E D F T G Y H U J K O L P ; ' -> notes 0..17
  localparam int KEYMAP_LEN = 18;
  localparam logic [7:0] KEYMAP [KEYMAP_LEN] = '{
    8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
    8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52
  };

  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND, SC_ERROR};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
// ps2_keymap : combinational scancode -> note index lookup
// Rev 1.0
// ============================================================================
module ps2_keymap
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS = 18
) (
  input  logic [7:0] code,
  output logic       hit,
  output logic [4:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = 5'd0;
    for (int i = 0; i < KEYMAP_LEN; i++) begin
      if ((i < NUM_KEYS) && (code == KEYMAP[i])) begin
        hit   = 1'b1;
        index = 5'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// ps2_key_tracker : PS/2 make/break decoder tracking held note keys
// Rev 1.0
// ============================================================================
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS = 18,
  parameter int MONO     = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          scan_data,
  input  logic                scan_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                note_valid,
  output logic [4:0]          note_index,
  output logic [5:0]          key_count,
  output logic                key_event,
  output logic [7:0]          last_code
);

  dec_state_t          state, state_nxt;
  logic                map_hit;
  logic [4:0]          map_index;
  logic                byte_ignored;
  logic                is_make;
  logic                is_break;
  logic [NUM_KEYS-1:0] key_onehot;
  logic [NUM_KEYS-1:0] held_nxt;

  ps2_keymap #(.NUM_KEYS(NUM_KEYS)) u_keymap (
    .code  (scan_data),
    .hit   (map_hit),
    .index (map_index)
  );

  assign byte_ignored = is_ignored(scan_data);

  always_comb begin : decode
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    if (scan_valid && !byte_ignored) begin
      case (state)
        ST_IDLE: begin
          if (scan_data == SC_BREAK)       state_nxt = ST_BRK;
          else if (scan_data == SC_EXTEND) state_nxt = ST_EXT;
          else                             is_make   = 1'b1;
        end
        ST_BRK: begin
          is_break  = 1'b1;
          state_nxt = ST_IDLE;
        end
        // Extended-key bytes are consumed without touching the key bitmap
        ST_EXT:     state_nxt = (scan_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin : key_update
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_onehot[i] = (map_index == 5'(i));
    end
    held_nxt = key_held;
    if (is_make && map_hit) begin
      held_nxt = (MONO != 0) ? key_onehot : (key_held | key_onehot);
    end else if (is_break && map_hit) begin
      held_nxt = key_held & ~key_onehot;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      key_held  <= '0;
      key_event <= 1'b0;
      last_code <= 8'd0;
    end else begin
      state     <= state_nxt;
      key_held  <= held_nxt;
      key_event <= (held_nxt != key_held);
      if (scan_valid) last_code <= scan_data;
    end
  end

  // In mono mode only one bit is ever set, so the lowest held index is the last press
  always_comb begin : summarize
    key_count  = 6'd0;
    note_index = 5'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      key_count = key_count + {5'd0, key_held[i]};
      if (key_held[i]) note_index = 5'(i);
    end
  end

  assign note_valid = |key_held;

endmodule
`default_nettype wire
